// File: rtl/micron_bus_pkg.sv
// Shared types and constants for the two-port cellular-RAM bus arbiter.
// Holds the FSM state encoding, burst codes and default bus widths.
package micron_bus_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;
    localparam int WDOG_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        WAITHI = 3'd2,
        BUSY   = 3'd3,
        DONE   = 3'd4,
        ABORT  = 3'd5
    } arb_state_t;

    localparam logic [1:0] BURST_1    = 2'b00;
    localparam logic [1:0] BURST_4    = 2'b01;
    localparam logic [1:0] BURST_8    = 2'b10;
    localparam logic [1:0] BURST_CONT = 2'b11;

    // Watchdog counter sticks at all-ones instead of wrapping.
    function automatic logic [WDOG_W-1:0] wdog_inc(input logic [WDOG_W-1:0] cnt);
        return (cnt == {WDOG_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/micron_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// and on contention the port that was not granted last wins.
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        if (req0 && req1) begin
            win = last_gnt ? 2'b01 : 2'b10;
        end else if (req0) begin
            win = 2'b01;
        end else if (req1) begin
            win = 2'b10;
        end
    end

endmodule

// File: rtl/micron_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the cellular-RAM controller,
// with a watchdog that aborts a transaction if the controller hangs.
module micron_bus_arbiter
    import micron_bus_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 64,
    parameter int MAXBUSY = 255
) (
    input  logic          clk50MHz,
    input  logic          rst_L,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [1:0]    burst0,
    input  logic [1:0]    burst1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          ctrl_start,
    output logic          ctrl_we,
    output logic [AW-1:0] ctrl_addr,
    output logic [1:0]    ctrl_burst,
    output logic [DW-1:0] ctrl_wdata,
    input  logic          ctrl_wait,
    input  logic [DW-1:0] ctrl_rdata
);

    localparam logic [WDOG_W-1:0] TIMEOUT_C = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] MAXBUSY_C = WDOG_W'(MAXBUSY);

    arb_state_t        state_reg;
    logic [1:0]        gnt_reg;
    logic [1:0]        done_reg;
    logic              last_gnt_reg;
    logic [WDOG_W-1:0] wdog_reg;
    logic [1:0]        win;

    rr_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_reg),
        .win      (win)
    );

    assign gnt0  = gnt_reg[0];
    assign gnt1  = gnt_reg[1];
    assign done0 = done_reg[0];
    assign done1 = done_reg[1];

    always_ff @(posedge clk50MHz or negedge rst_L) begin
        if (!rst_L) begin
            state_reg    <= IDLE;
            gnt_reg      <= 2'b00;
            done_reg     <= 2'b00;
            err          <= 1'b0;
            rdata        <= '0;
            ctrl_start   <= 1'b0;
            ctrl_we      <= 1'b0;
            ctrl_addr    <= '0;
            ctrl_burst   <= 2'b00;
            ctrl_wdata   <= '0;
            last_gnt_reg <= 1'b1;
            wdog_reg     <= '0;
        end else begin
            ctrl_start <= 1'b0;
            done_reg   <= 2'b00;
            err        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // ctrl_* only change here, so they stay frozen for the
                    // whole transaction regardless of what the requester does.
                    if (win != 2'b00) begin
                        gnt_reg      <= win;
                        last_gnt_reg <= win[1];
                        ctrl_we      <= win[1] ? we1    : we0;
                        ctrl_addr    <= win[1] ? addr1  : addr0;
                        ctrl_burst   <= win[1] ? burst1 : burst0;
                        ctrl_wdata   <= win[1] ? wdata1 : wdata0;
                        state_reg    <= START;
                    end
                end
                START: begin
                    ctrl_start <= 1'b1;
                    wdog_reg   <= '0;
                    state_reg  <= WAITHI;
                end
                WAITHI: begin
                    if (ctrl_wait) begin
                        wdog_reg  <= '0;
                        state_reg <= BUSY;
                    end else if (wdog_reg == TIMEOUT_C) begin
                        done_reg  <= gnt_reg;
                        err       <= 1'b1;
                        state_reg <= ABORT;
                    end else begin
                        wdog_reg <= wdog_inc(wdog_reg);
                    end
                end
                BUSY: begin
                    if (!ctrl_wait) begin
                        done_reg  <= gnt_reg;
                        state_reg <= DONE;
                        if (!ctrl_we) begin
                            rdata <= ctrl_rdata;
                        end
                    end else if (wdog_reg == MAXBUSY_C) begin
                        done_reg  <= gnt_reg;
                        err       <= 1'b1;
                        state_reg <= ABORT;
                    end else begin
                        wdog_reg <= wdog_inc(wdog_reg);
                    end
                end
                DONE, ABORT: begin
                    // No re-grant here: the next winner is picked from IDLE.
                    gnt_reg   <= 2'b00;
                    state_reg <= IDLE;
                end
                default: begin
                    gnt_reg   <= 2'b00;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
